// File: rtl/impact_pkg.sv
// Shared definitions for the IMPACT serial command front-end:
// frame geometry, field offsets and the controller state encoding.
package impact_pkg;
    localparam int FRAME_W  = 24;
    localparam int OP_BIT   = 23;
    localparam int BANK_LSB = 20;
    localparam int BYTE_LSB = 18;
    localparam int WORD_LSB = 8;

    typedef enum logic [2:0] {IDLE, SHIFT, EXEC, WAIT, RESP} state_t;
endpackage

// File: rtl/impact_piso8.sv
// 8-bit load / serial-out register for read responses, MSB first.
// 'last' is high while the eighth bit is on sdo.
module impact_piso8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic [7:0] din,
    output logic       sdo,
    output logic       sdo_valid,
    output logic       last
);
    logic [7:0] rdbuf;
    logic [2:0] rcnt;
    logic       act;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdbuf <= '0;
            rcnt  <= '0;
            act   <= 1'b0;
        end else if (ld) begin
            rdbuf <= din;
            rcnt  <= '0;
            act   <= 1'b1;
        end else if (act) begin
            rcnt <= rcnt + 3'd1;
            if (rcnt == 3'd7)
                act <= 1'b0;
        end
    end

    assign sdo       = act & rdbuf[3'd7 - rcnt];
    assign sdo_valid = act;
    assign last      = act && (rcnt == 3'd7);
endmodule

// File: rtl/impact_serial_ctrl.sv
// Serial command front-end for user_proj_IMPACT_HEAD: deserialises 24-bit
// frames into memory strobes/fields and returns read bytes serially.
module impact_serial_ctrl #(
    parameter int RD_LAT  = 1,
    parameter int FRAME_W = impact_pkg::FRAME_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sdi,
    input  logic       sdi_valid,
    output logic       sdo,
    output logic       sdo_valid,
    output logic       busy,
    output logic       ovr,
    output logic [1:0] mem_bank,
    output logic [1:0] mem_byte,
    output logic [9:0] mem_word,
    output logic [7:0] mem_din,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] mem_dout
);
    import impact_pkg::*;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame;
    logic [4:0]         bcnt;
    logic [1:0]         wcnt;
    logic               take;
    logic               ld;
    logic               resp_last;

    assign take  = sdi_valid & ~cs_n;
    assign frame = {shreg[FRAME_W-2:0], sdi};
    assign busy  = (state == EXEC) || (state == WAIT) || (state == RESP);
    // Capture happens on the edge that ends the last wait cycle.
    assign ld    = (state == WAIT) && (wcnt == 2'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bcnt     <= '0;
            wcnt     <= '0;
            mem_bank <= '0;
            mem_byte <= '0;
            mem_word <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            ovr    <= busy & take;
            case (state)
                IDLE: begin
                    if (take) begin
                        shreg <= frame;
                        bcnt  <= 5'd1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_n) begin
                        bcnt  <= '0;
                        state <= IDLE;
                    end else if (sdi_valid) begin
                        shreg <= frame;
                        if (bcnt == 5'(FRAME_W - 1)) begin
                            // Strobe is registered here so it is high during EXEC.
                            bcnt     <= '0;
                            mem_bank <= frame[BANK_LSB +: 2];
                            mem_byte <= frame[BYTE_LSB +: 2];
                            mem_word <= frame[WORD_LSB +: 10];
                            mem_din  <= frame[7:0];
                            mem_we   <= frame[OP_BIT];
                            mem_re   <= ~frame[OP_BIT];
                            state    <= EXEC;
                        end else begin
                            bcnt <= bcnt + 5'd1;
                        end
                    end
                end
                EXEC: begin
                    if (shreg[OP_BIT]) begin
                        state <= IDLE;
                    end else begin
                        wcnt  <= 2'(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt == 2'd1)
                        state <= RESP;
                    else
                        wcnt <= wcnt - 2'd1;
                end
                RESP: begin
                    if (resp_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    impact_piso8 u_piso (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld        (ld),
        .din       (mem_dout),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .last      (resp_last)
    );
endmodule

// File: tb/tb_impact_serial_ctrl.sv
// Bench for impact_serial_ctrl: two instances (RD_LAT 1 and 3) share the
// serial stimulus; a cycle-count model predicts every output each cycle.
module tb_impact_serial_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0, cs_n = 1'b1, sdi = 1'b0, sdi_valid = 1'b0;
    logic [1:0]      sdo_a, sv_a, busy_a, ovr_a, we_a, re_a;
    logic [1:0][1:0] bank_a, byte_a;
    logic [1:0][9:0] word_a;
    logic [1:0][7:0] din_a;
    logic [1:0][7:0] dout_a = {8'hA5, 8'hA5};

    int errs = 0, chks = 0, cyc = 0;
    bit mdl_on = 1'b0;

    always #5 clk = ~clk;

    impact_serial_ctrl #(.RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sdi(sdi), .sdi_valid(sdi_valid),
        .sdo(sdo_a[0]), .sdo_valid(sv_a[0]), .busy(busy_a[0]), .ovr(ovr_a[0]),
        .mem_bank(bank_a[0]), .mem_byte(byte_a[0]), .mem_word(word_a[0]),
        .mem_din(din_a[0]), .mem_we(we_a[0]), .mem_re(re_a[0]), .mem_dout(dout_a[0]));

    impact_serial_ctrl #(.RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sdi(sdi), .sdi_valid(sdi_valid),
        .sdo(sdo_a[1]), .sdo_valid(sv_a[1]), .busy(busy_a[1]), .ovr(ovr_a[1]),
        .mem_bank(bank_a[1]), .mem_byte(byte_a[1]), .mem_word(word_a[1]),
        .mem_din(din_a[1]), .mem_we(we_a[1]), .mem_re(re_a[1]), .mem_dout(dout_a[1]));

    function automatic int rdl(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, d, act, exp);
        end
    endtask

    function automatic logic [27:0] outv(input int d);
        return {sdo_a[d], sv_a[d], busy_a[d], ovr_a[d], bank_a[d], byte_a[d],
                word_a[d], din_a[d], we_a[d], re_a[d]};
    endfunction

    // Behavioural model: a completed frame opens a busy window of
    // 1 (write) or RD_LAT+9 (read) cycles; position k inside it fixes outputs.
    int         nb[2], bl[2], tot[2];
    logic [23:0] fr[2];
    logic       opx[2], eovr[2];
    logic [7:0] rdat[2], edin[2];
    logic [1:0] ebank[2], ebyte[2];
    logic [9:0] eword[2];
    logic [7:0] mem[2][16384];

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                nb[d] = 0; bl[d] = 0; tot[d] = 0; opx[d] = 1'b0; eovr[d] = 1'b0;
                ebank[d] = '0; ebyte[d] = '0; eword[d] = '0; edin[d] = '0;
                mdl_on = 1'b1;
            end else begin
                eovr[d] = (bl[d] > 0) && sdi_valid && !cs_n;
                if (bl[d] > 0) bl[d]--;
                else if (cs_n) nb[d] = 0;
                else if (sdi_valid) begin
                    fr[d] = {fr[d][22:0], sdi};
                    nb[d]++;
                    if (nb[d] == 24) begin
                        nb[d] = 0;
                        opx[d] = fr[d][23];
                        ebank[d] = fr[d][21:20]; ebyte[d] = fr[d][19:18];
                        eword[d] = fr[d][17:8];  edin[d] = fr[d][7:0];
                        if (!opx[d]) rdat[d] = mem[d][fr[d][21:8]];
                        tot[d] = opx[d] ? 1 : rdl(d) + 9;
                        bl[d] = tot[d];
                    end
                end
            end
        end
    end

    function automatic logic [27:0] expv(input int d);
        int k, rl, idx;
        logic bz, rd, svv, so;
        bz  = bl[d] > 0;
        k   = tot[d] - bl[d];
        rl  = rdl(d);
        rd  = bz && !opx[d];
        svv = rd && (k >= rl + 1);
        idx = svv ? 7 - (k - rl - 1) : 0;
        so  = svv ? rdat[d][idx] : 1'b0;
        return {so, svv, bz, eovr[d], ebank[d], ebyte[d], eword[d], edin[d],
                bz && k == 0 && opx[d], rd && k == 0};
    endfunction

    // Compare, event log and memory behaviour, all on the falling edge.
    int we_cnt[2] = '{0, 0}, re_cnt[2] = '{0, 0}, sv_cnt[2] = '{0, 0}, ovr_cnt[2] = '{0, 0};
    int re_cyc[2] = '{0, 0}, first_sv[2] = '{0, 0}, sv_seen[2] = '{0, 0}, pend[2] = '{0, 0};
    logic [7:0]  sdo_byte[2];
    logic [13:0] paddr[2];

    always @(negedge clk) begin
        if (mdl_on) begin
            for (int d = 0; d < 2; d++) begin
                chk("outputs", d, 32'(outv(d)), 32'(expv(d)));
                if (we_a[d]) begin
                    we_cnt[d]++;
                    mem[d][{bank_a[d], byte_a[d], word_a[d]}] = din_a[d];
                end
                if (re_a[d]) begin
                    re_cnt[d]++; re_cyc[d] = cyc; sv_seen[d] = 0;
                    pend[d] = rdl(d); paddr[d] = {bank_a[d], byte_a[d], word_a[d]};
                    dout_a[d] = 8'hA5;
                end else if (pend[d] > 0) begin
                    pend[d]--;
                    dout_a[d] = (pend[d] == 0) ? mem[d][paddr[d]] : 8'hA5;
                end else begin
                    dout_a[d] = 8'hA5;
                end
                if (sv_a[d]) begin
                    if (sv_seen[d] == 0) first_sv[d] = cyc;
                    sdo_byte[d] = {sdo_byte[d][6:0], sdo_a[d]};
                    sv_seen[d]++; sv_cnt[d]++;
                end
                if (ovr_a[d]) ovr_cnt[d]++;
            end
        end
    end

    task automatic send_bits(input logic [23:0] f, input int n, input int gap);
        for (int i = 23; i > 23 - n; i--) begin
            int g;
            cs_n = 1'b0;
            g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            repeat (g) begin
                sdi_valid = 1'b0;
                @(negedge clk);
            end
            sdi = f[i]; sdi_valid = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [23:0] f, input int gap);
        send_bits(f, 24, gap);
        sdi_valid = 1'b0; cs_n = 1'b1;
    endtask

    task automatic idle(input int n);
        sdi_valid = 1'b0; cs_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic fields(input string nm, input logic [1:0] b, input logic [1:0] y,
                          input logic [9:0] w, input logic [7:0] v);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_bank"}, d, 32'(bank_a[d]), 32'(b));
            chk({nm, "_byte"}, d, 32'(byte_a[d]), 32'(y));
            chk({nm, "_word"}, d, 32'(word_a[d]), 32'(w));
            chk({nm, "_din"},  d, 32'(din_a[d]),  32'(v));
        end
    endtask

    initial begin
        int ov0[2];
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 16384; a++) mem[d][a] = 8'h00;
            mem[d][{2'd3, 2'd1, 10'h15A}] = 8'h7E;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("rst_zero", d, 32'(outv(d)), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Read 0x355A00 -> 0x7E returned MSB first
        send_frame(24'h355A00, 0);
        idle(16);
        for (int d = 0; d < 2; d++) begin
            chk("rd_re_cnt", d, 32'(re_cnt[d]), 32'd1);
            chk("rd_we_cnt", d, 32'(we_cnt[d]), 32'd0);
            chk("rd_byte",   d, 32'(sdo_byte[d]), 32'h7E);
            chk("rd_nbits",  d, 32'(sv_cnt[d]), 32'd8);
            chk("rd_lat",    d, 32'(first_sv[d] - re_cyc[d]), 32'(rdl(d) + 1));
        end

        // Write 0xB55AC3
        send_frame(24'hB55AC3, 0);
        idle(2);
        for (int d = 0; d < 2; d++) begin
            chk("wr_we_cnt", d, 32'(we_cnt[d]), 32'd1);
            chk("wr_no_sdo", d, 32'(sv_cnt[d]), 32'd8);
        end
        fields("wr", 2'd3, 2'd1, 10'h15A, 8'hC3);

        // Back-to-back writes, second starts on IDLE re-entry
        send_frame(24'h8FFF01, 0);
        idle(1);
        send_frame(24'hC000AA, 0);
        idle(2);
        for (int d = 0; d < 2; d++) chk("b2b_we_cnt", d, 32'(we_cnt[d]), 32'd3);
        fields("b2b", 2'd0, 2'd0, 10'h000, 8'hAA);

        // Abort after 12 bits, then a full write
        send_bits(24'hFFFFFF, 12, 0);
        idle(2);
        send_frame(24'hE6A55F, 0);
        idle(2);
        for (int d = 0; d < 2; d++) chk("abort_we_cnt", d, 32'(we_cnt[d]), 32'd4);
        fields("abort", 2'd2, 2'd1, 10'h2A5, 8'h5F);

        // cs_n rises on the cycle bit 24 would arrive
        send_bits(24'h812345, 23, 0);
        cs_n = 1'b1; sdi = 1'b1; sdi_valid = 1'b1;
        @(negedge clk);
        idle(3);
        for (int d = 0; d < 2; d++) begin
            chk("late_abort_we", d, 32'(we_cnt[d]), 32'd4);
            chk("late_abort_re", d, 32'(re_cnt[d]), 32'd1);
        end
        fields("late_abort", 2'd2, 2'd1, 10'h2A5, 8'h5F);

        // Overrun: sdi_valid held through a read
        for (int d = 0; d < 2; d++) ov0[d] = ovr_cnt[d];
        send_bits(24'h66A500, 24, 0);
        repeat (14) begin
            sdi = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        idle(4);
        for (int d = 0; d < 2; d++) begin
            chk("ovr_pulses", d, 32'(ovr_cnt[d] - ov0[d]), 32'(rdl(d) + 9));
            chk("ovr_rdata",  d, 32'(sdo_byte[d]), 32'h5F);
        end
        send_frame(24'h9ABCDE, 0);
        idle(2);
        for (int d = 0; d < 2; d++) chk("post_ovr_we", d, 32'(we_cnt[d]), 32'd5);
        fields("post_ovr", 2'd1, 2'd2, 10'h2BC, 8'hDE);

        // Reset during the response
        send_frame(24'h355A00, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("midrst_zero", d, 32'(outv(d)), 32'd0);
            chk("midrst_bits", d, 32'(sv_seen[d]), 32'(4 - rdl(d)));
        end
        rst_n = 1'b1;
        idle(1);
        send_frame(24'hB55AC3, 0);
        idle(2);
        for (int d = 0; d < 2; d++) chk("post_rst_we", d, 32'(we_cnt[d]), 32'd6);
        fields("post_rst", 2'd3, 2'd1, 10'h15A, 8'hC3);

        // Gapped write and read
        send_frame(24'hD3C996, 5);
        idle(2);
        for (int d = 0; d < 2; d++) chk("gap_we_cnt", d, 32'(we_cnt[d]), 32'd7);
        fields("gap", 2'd1, 2'd0, 10'h3C9, 8'h96);
        send_frame(24'h355A00, 5);
        idle(16);
        for (int d = 0; d < 2; d++) begin
            chk("gap_re_cnt", d, 32'(re_cnt[d]), 32'd4);
            chk("gap_rbyte",  d, 32'(sdo_byte[d]), 32'hC3);
            chk("gap_lat",    d, 32'(first_sv[d] - re_cyc[d]), 32'(rdl(d) + 1));
        end

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
